// File: rtl/delay_timer_pkg.sv
// Shared types for the multi-channel delay timer.
// Holds the channel state enum and the channel mode encodings.
package delay_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/delay_channel.sv
// One delay channel: IDLE/HOLD/DONE FSM with sub-tick and tick counters.
// Optional PAUSE input when MULTI_DELAY_TIMER_PAUSE_EN is defined.
module delay_channel
  import delay_timer_pkg::*;
#(
  parameter int CNT_W = 12,
  parameter int DIV   = 25000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic             mode,
`ifdef MULTI_DELAY_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             fin,
  output logic             pulse,
  output logic             busy
);

  localparam int SUB_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(DIV - 1);

  state_e           state_q, state_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;

  logic             run;
  logic [CNT_W-1:0] cnt_eff;
  logic             os_match;
  logic             pd_match;

`ifdef MULTI_DELAY_TIMER_PAUSE_EN
  assign run = ~pause;
`else
  assign run = 1'b1;
`endif

  // One-shot completes one cycle after reaching the count; periodic
  // fires as soon as it is reached, with count 0 stretched to 1.
  assign cnt_eff  = (cnt_q == '0) ? CNT_W'(1) : cnt_q;
  assign os_match = (tick_q == cnt_q) && (sub_q == SUB_W'(1));
  assign pd_match = (tick_q == cnt_eff) && (sub_q == '0);

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        sub_d  = '0;
        tick_d = '0;
        if (en) begin
          state_d = HOLD;
          cnt_d   = cnt;
          mode_d  = mode;
        end
      end
      HOLD: begin
        if (!en) begin
          state_d = IDLE;
          sub_d   = '0;
          tick_d  = '0;
        end else if (mode_q == MODE_ONESHOT && os_match) begin
          state_d = DONE;
        end else if (mode_q == MODE_PERIODIC && pd_match) begin
          sub_d  = '0;
          tick_d = '0;
          cnt_d  = cnt;
        end else if (run) begin
          if (sub_q == SUB_MAX) begin
            sub_d  = '0;
            tick_d = tick_q + CNT_W'(1);
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
      end
      DONE: begin
        if (!en) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sub_d   = '0;
        tick_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      sub_q   <= '0;
      tick_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_ONESHOT;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign fin   = (state_q == DONE) && en;
  assign pulse = (state_q == HOLD) && (mode_q == MODE_PERIODIC)
               && pd_match && en;
  assign busy  = (state_q == HOLD);

endmodule

// File: rtl/multi_delay_timer.sv
// N_CH independent delay channels sharing one clock and tick divider ratio.
// Define MULTI_DELAY_TIMER_PAUSE_EN to add the global PAUSE input.
module multi_delay_timer
  import delay_timer_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 12,
  parameter int CLK_HZ  = 25_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_CH-1:0]       DELAY_EN,
  input  logic [N_CH*CNT_W-1:0] DELAY_CNT,
  input  logic [N_CH-1:0]       MODE,
`ifdef MULTI_DELAY_TIMER_PAUSE_EN
  input  logic                  PAUSE,
`endif
  output logic [N_CH-1:0]       DELAY_FIN,
  output logic [N_CH-1:0]       TICK_PULSE,
  output logic                  BUSY
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (N_CH < 1 || N_CH > 16 || CNT_W < 1 || CNT_W > 16) begin : g_bad_size
    $error("N_CH and CNT_W must be in 1..16");
  end

  logic [N_CH-1:0] busy_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    delay_channel #(
      .CNT_W (CNT_W),
      .DIV   (DIV)
    ) u_ch (
      .CLK   (CLK),
      .RST   (RST),
      .en    (DELAY_EN[i]),
      .cnt   (DELAY_CNT[i*CNT_W +: CNT_W]),
      .mode  (MODE[i]),
`ifdef MULTI_DELAY_TIMER_PAUSE_EN
      .pause (PAUSE),
`endif
      .fin   (DELAY_FIN[i]),
      .pulse (TICK_PULSE[i]),
      .busy  (busy_w[i])
    );
  end

  assign BUSY = |busy_w;

endmodule

// File: tb/tb_multi_delay_timer.sv
// Directed bench for multi_delay_timer (DIV=10, 4 channels, 4-bit counts).
// Covers the PAUSE case when MULTI_DELAY_TIMER_PAUSE_EN is defined.
module tb_multi_delay_timer;

  logic        CLK;
  logic        RST;
  logic [3:0]  DELAY_EN;
  logic [15:0] DELAY_CNT;
  logic [3:0]  MODE;
`ifdef MULTI_DELAY_TIMER_PAUSE_EN
  logic        PAUSE;
`endif
  logic [3:0]  DELAY_FIN;
  logic [3:0]  TICK_PULSE;
  logic        BUSY;

  int n_chk  = 0;
  int n_fail = 0;

  multi_delay_timer #(
    .N_CH    (4),
    .CNT_W   (4),
    .CLK_HZ  (1000),
    .TICK_HZ (100)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DELAY_EN   (DELAY_EN),
    .DELAY_CNT  (DELAY_CNT),
    .MODE       (MODE),
`ifdef MULTI_DELAY_TIMER_PAUSE_EN
    .PAUSE      (PAUSE),
`endif
    .DELAY_FIN  (DELAY_FIN),
    .TICK_PULSE (TICK_PULSE),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST       = 1'b0;
    DELAY_EN  = '0;
    DELAY_CNT = '0;
    MODE      = '0;
`ifdef MULTI_DELAY_TIMER_PAUSE_EN
    PAUSE     = 1'b0;
`endif
    step(2);
    chk("rst_fin", 32'(DELAY_FIN), 0);
    chk("rst_pulse", 32'(TICK_PULSE), 0);
    chk("rst_busy", 32'(BUSY), 0);
    RST = 1'b1;
    step(1);

    // ch0 one-shot count 3; count change mid-HOLD is ignored
    DELAY_CNT[3:0] = 4'd3;
    DELAY_EN[0] = 1'b1;
    step(1);
    chk("a_busy0", 32'(BUSY), 1);
    chk("a_fin0", 32'(DELAY_FIN), 0);
    step(5);
    DELAY_CNT[3:0] = 4'd1;
    step(26);
    chk("a_fin31", 32'(DELAY_FIN), 0);
    step(1);
    chk("a_fin32", 32'(DELAY_FIN), 4'b0001);
    chk("a_busy32", 32'(BUSY), 0);
    step(5);
    chk("a_hold", 32'(DELAY_FIN), 4'b0001);
    DELAY_EN[0] = 1'b0;
    #1;
    chk("a_drop", 32'(DELAY_FIN), 0);
    step(1);
    DELAY_EN[0] = 1'b1;
    #1;
    chk("a_idle", 32'(DELAY_FIN), 0);
    step(1);
    chk("a_rehold", 32'(BUSY), 1);
    DELAY_EN[0] = 1'b0;
    step(1);
    chk("a_end", 32'(BUSY), 0);

    // ch1 periodic count 2: pulses at edges 20, 41
    DELAY_CNT[7:4] = 4'd2;
    MODE[1] = 1'b1;
    DELAY_EN[1] = 1'b1;
    step(1);
    step(19);
    chk("b_p19", 32'(TICK_PULSE), 0);
    step(1);
    chk("b_p20", 32'(TICK_PULSE), 4'b0010);
    step(1);
    chk("b_p21", 32'(TICK_PULSE), 0);
    step(19);
    chk("b_p40", 32'(TICK_PULSE), 0);
    step(1);
    chk("b_p41", 32'(TICK_PULSE), 4'b0010);
    chk("b_fin", 32'(DELAY_FIN), 0);
    step(1);
    chk("b_p42", 32'(TICK_PULSE), 0);
    DELAY_EN[1] = 1'b0;
    MODE[1] = 1'b0;
    step(1);
    chk("b_end", 32'(BUSY), 0);

    // ch2 one-shot count 5 aborted, then count 0
    DELAY_CNT[11:8] = 4'd5;
    DELAY_EN[2] = 1'b1;
    step(1);
    step(19);
    chk("c_busy", 32'(BUSY), 1);
    DELAY_EN[2] = 1'b0;
    step(1);
    chk("c_abort", 32'(BUSY), 0);
    chk("c_nofin", 32'(DELAY_FIN), 0);
    DELAY_CNT[11:8] = 4'd0;
    DELAY_EN[2] = 1'b1;
    step(1);
    chk("c_z0", 32'(DELAY_FIN), 0);
    step(1);
    chk("c_z1", 32'(DELAY_FIN), 0);
    step(1);
    chk("c_z2", 32'(DELAY_FIN), 4'b0100);
    DELAY_EN[2] = 1'b0;
    step(1);

    // all channels together, counts 1/2/3/15
    DELAY_CNT = {4'd15, 4'd3, 4'd2, 4'd1};
    DELAY_EN = 4'hF;
    step(1);
    step(11);
    chk("d_e11", 32'(DELAY_FIN), 0);
    step(1);
    chk("d_e12", 32'(DELAY_FIN), 4'b0001);
    step(9);
    chk("d_e21", 32'(DELAY_FIN), 4'b0001);
    step(1);
    chk("d_e22", 32'(DELAY_FIN), 4'b0011);
    step(10);
    chk("d_e32", 32'(DELAY_FIN), 4'b0111);
    step(119);
    chk("d_e151", 32'(DELAY_FIN), 4'b0111);
    chk("d_busy151", 32'(BUSY), 1);
    step(1);
    chk("d_e152", 32'(DELAY_FIN), 4'b1111);
    chk("d_busy152", 32'(BUSY), 0);
    DELAY_EN = '0;
    step(1);

    // reset mid-HOLD, restart after release
    DELAY_CNT = 16'h0003;
    DELAY_EN[0] = 1'b1;
    step(1);
    step(14);
    chk("e_busy", 32'(BUSY), 1);
    RST = 1'b0;
    step(1);
    chk("e_rbusy", 32'(BUSY), 0);
    chk("e_rfin", 32'(DELAY_FIN), 0);
    step(1);
    RST = 1'b1;
    step(1);
    chk("e_restart", 32'(BUSY), 1);
    step(31);
    chk("e_r31", 32'(DELAY_FIN), 0);
    step(1);
    chk("e_r32", 32'(DELAY_FIN), 4'b0001);
    DELAY_EN[0] = 1'b0;
    step(1);

`ifdef MULTI_DELAY_TIMER_PAUSE_EN
    // count 2 with PAUSE high for 7 edges: done at edge 29
    DELAY_CNT = 16'h0002;
    DELAY_EN[0] = 1'b1;
    step(1);
    step(4);
    PAUSE = 1'b1;
    step(7);
    PAUSE = 1'b0;
    step(17);
    chk("f_e28", 32'(DELAY_FIN), 0);
    step(1);
    chk("f_e29", 32'(DELAY_FIN), 4'b0001);
    DELAY_EN[0] = 1'b0;
    step(1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
